// File: rtl/seven_segment_display_capture.sv
// seven_segment_display_capture
//   Receive side of a 4-digit multiplexed 7-segment interface. It watches the
//   active-low segment and anode lines and recovers the four displayed digits,
//   their decimal points, frame completion and protocol errors.
//
//   Parameters
//     SETTLE_CYCLES  : identical consecutive samples needed before a capture (>=1)
//     TIMEOUT_CYCLES : cycles without any capture before scan_stall asserts (>=2)
//
//   Ports
//     clk, reset            : clock, asynchronous active-high reset
//     CA..CG, DP            : segment a..g and decimal point, active-low
//     AN1..AN4              : anodes, active-low (AN1=sec_dig1 .. AN4=min_dig2)
//     sec_dig1..min_dig2    : last captured value per digit
//     dp_state              : last captured DP per digit, bit i = AN(i+1)
//     digit_valid           : sticky, bit i set once digit i has been captured
//     frame_done            : pulse when all four digits captured since last pulse
//     anode_err             : pulse when more than one anode is active in a sample
//     seg_err               : pulse when a settled non-blank pattern is not a hex glyph
//     scan_stall            : level, no capture for TIMEOUT_CYCLES cycles
module seven_segment_display_capture #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CA,
   input  logic       CB,
   input  logic       CC,
   input  logic       CD,
   input  logic       CE,
   input  logic       CF,
   input  logic       CG,
   input  logic       DP,
   input  logic       AN1,
   input  logic       AN2,
   input  logic       AN3,
   input  logic       AN4,
   output logic [3:0] sec_dig1,
   output logic [3:0] sec_dig2,
   output logic [3:0] min_dig1,
   output logic [3:0] min_dig2,
   output logic [3:0] dp_state,
   output logic [3:0] digit_valid,
   output logic       frame_done,
   output logic       anode_err,
   output logic       seg_err,
   output logic       scan_stall
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] HELD   = 2'd2;

   // {hit, value} for a {gfedcba} active-high pattern
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      case (seg)
         7'h3F: decode_seg = 5'h10;
         7'h06: decode_seg = 5'h11;
         7'h5B: decode_seg = 5'h12;
         7'h4F: decode_seg = 5'h13;
         7'h66: decode_seg = 5'h14;
         7'h6D: decode_seg = 5'h15;
         7'h7D: decode_seg = 5'h16;
         7'h07: decode_seg = 5'h17;
         7'h7F: decode_seg = 5'h18;
         7'h6F: decode_seg = 5'h19;
         7'h77: decode_seg = 5'h1A;
         7'h7C: decode_seg = 5'h1B;
         7'h39: decode_seg = 5'h1C;
         7'h5E: decode_seg = 5'h1D;
         7'h79: decode_seg = 5'h1E;
         7'h71: decode_seg = 5'h1F;
         default: decode_seg = 5'h00;
      endcase
   endfunction

   function automatic logic [1:0] anode_idx(input logic [3:0] an);
      case (an)
         4'b0010: anode_idx = 2'd1;
         4'b0100: anode_idx = 2'd2;
         4'b1000: anode_idx = 2'd3;
         default: anode_idx = 2'd0;
      endcase
   endfunction

   // Stage p0/p1: two-flop synchroniser; resets to the idle (all-high) pin level
   // so that no phantom anode is seen right after reset.
   logic [11:0] sync_p0, sync_p1;
   logic [11:0] samp_p2, prev_p2;
   logic [3:0]  an_p2;
   logic        changed_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '1;
         sync_p1 <= '1;
         prev_p2 <= '0;
      end else begin
         sync_p0 <= {AN4, AN3, AN2, AN1, CG, CF, CE, CD, CC, CB, CA, DP};
         sync_p1 <= sync_p0;
         prev_p2 <= samp_p2;
      end
   end

   // Stage p2: active-high sample {an, seg, dp} and dwell FSM
   assign samp_p2    = ~sync_p1;
   assign an_p2      = samp_p2[11:8];
   assign changed_p2 = (samp_p2 != prev_p2);

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cap_nxt, anode_err_nxt, restart;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cap_nxt       = 1'b0;
      anode_err_nxt = 1'b0;
      restart       = 1'b0;
      case (state)
         IDLE:   restart = 1'b1;
         SETTLE: begin
            if (changed_p2) begin
               restart = 1'b1;
            end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
               cap_nxt   = 1'b1;
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD:    restart = changed_p2;
         default: state_nxt = IDLE;
      endcase
      // A new or changed sample is judged as if seen from IDLE
      if (restart) begin
         if (an_p2 == 4'b0000) begin
            state_nxt = IDLE;
         end else if ($onehot(an_p2)) begin
            if (SETTLE_CYCLES == 1) begin
               cap_nxt   = 1'b1;
               state_nxt = HELD;
            end else begin
               cnt_nxt   = CNT_W'(1);
               state_nxt = SETTLE;
            end
         end else begin
            anode_err_nxt = 1'b1;
            state_nxt     = IDLE;
         end
      end
   end

   logic vld_p3;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         anode_err <= 1'b0;
         vld_p3    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         anode_err <= anode_err_nxt;
         vld_p3    <= cap_nxt;
      end
   end

   // Stage p3: registered capture decision, applied to the digit registers
   logic [11:0] cap_p3;

   always_ff @(posedge clk) begin
      cap_p3 <= samp_p2;
   end

   logic [1:0] cap_idx;
   logic [6:0] cap_seg;
   logic       cap_dp;
   logic [4:0] cap_dec;
   logic [3:0] mask, mask_nxt;

   assign cap_idx  = anode_idx(cap_p3[11:8]);
   assign cap_seg  = cap_p3[7:1];
   assign cap_dp   = cap_p3[0];
   assign cap_dec  = decode_seg(cap_seg);
   assign mask_nxt = mask | cap_p3[11:8];

   logic [3:0]       digit_q [4];
   logic [TMO_W-1:0] tmo;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) digit_q[i] <= 4'd0;
         dp_state    <= 4'd0;
         digit_valid <= 4'd0;
         mask        <= 4'd0;
         frame_done  <= 1'b0;
         seg_err     <= 1'b0;
         tmo         <= '0;
      end else begin
         frame_done <= 1'b0;
         seg_err    <= 1'b0;
         if (vld_p3) begin
            tmo <= '0;
            if (cap_seg == 7'h00) begin
               // blank digit: only the decimal point is meaningful
               dp_state[cap_idx] <= cap_dp;
            end else if (cap_dec[4]) begin
               digit_q[cap_idx]     <= cap_dec[3:0];
               dp_state[cap_idx]    <= cap_dp;
               digit_valid[cap_idx] <= 1'b1;
               if (mask_nxt == 4'hF) begin
                  frame_done <= 1'b1;
                  mask       <= 4'd0;
               end else begin
                  mask <= mask_nxt;
               end
            end else begin
               seg_err <= 1'b1;
            end
         end else if (tmo != TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo <= tmo + TMO_W'(1);
         end
      end
   end

   assign scan_stall = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
   assign sec_dig1   = digit_q[0];
   assign sec_dig2   = digit_q[1];
   assign min_dig1   = digit_q[2];
   assign min_dig2   = digit_q[3];

endmodule

// File: tb/tb_seven_segment_display_capture.sv
module tb_seven_segment_display_capture;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic CA = 1'b1, CB = 1'b1, CC = 1'b1, CD = 1'b1, CE = 1'b1, CF = 1'b1, CG = 1'b1, DP = 1'b1;
   logic AN1 = 1'b1, AN2 = 1'b1, AN3 = 1'b1, AN4 = 1'b1;
   logic [3:0] sec_dig1, sec_dig2, min_dig1, min_dig2, dp_state, digit_valid;
   logic frame_done, anode_err, seg_err, scan_stall;

   int checks = 0;
   int errors = 0;
   int fd_n = 0, ae_n = 0, se_n = 0;
   int snap;

   seven_segment_display_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(65536)) dut (
      .clk(clk), .reset(reset),
      .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP),
      .AN1(AN1), .AN2(AN2), .AN3(AN3), .AN4(AN4),
      .sec_dig1(sec_dig1), .sec_dig2(sec_dig2), .min_dig1(min_dig1), .min_dig2(min_dig2),
      .dp_state(dp_state), .digit_valid(digit_valid), .frame_done(frame_done),
      .anode_err(anode_err), .seg_err(seg_err), .scan_stall(scan_stall)
   );

   always #5 clk = ~clk;

   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (frame_done) fd_n++;
      if (anode_err)  ae_n++;
      if (seg_err)    se_n++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // an/seg/dp given active-high; seg is {gfedcba}
   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
      {AN4, AN3, AN2, AN1} = ~an;
      {CG, CF, CE, CD, CC, CB, CA} = ~seg;
      DP = ~dp;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      tick(3);
      reset = 1'b0;
      tick(3);
      check("rst_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 16'h0000);
      check("rst_dp_valid", {dp_state, digit_valid}, 8'h00);
      check("rst_pulses", {frame_done, anode_err, seg_err, scan_stall}, 4'h0);

      // T2: dwell too short
      drive(4'b0001, 7'h6D, 1'b0);
      tick(3);
      drive(4'b0000, 7'h00, 1'b0);
      tick(10);
      check("t2_valid", digit_valid, 4'h0);
      check("t2_sec1", sec_dig1, 4'h0);

      // latency: 2 sync + 4 settle + 1
      drive(4'b0001, 7'h07, 1'b0);
      tick(6);
      check("lat_early", sec_dig1, 4'h0);
      tick(1);
      check("lat_sec1", sec_dig1, 4'h7);
      check("lat_valid", digit_valid, 4'h1);

      // T1: full scan
      snap = fd_n;
      drive(4'b0001, 7'h06, 1'b0); tick(8);
      drive(4'b0010, 7'h5B, 1'b1); tick(8);
      drive(4'b0100, 7'h4F, 1'b0); tick(8);
      drive(4'b1000, 7'h66, 1'b0); tick(8);
      drive(4'b0000, 7'h00, 1'b0); tick(10);
      check("t1_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 16'h1234);
      check("t1_valid", digit_valid, 4'hF);
      check("t1_dp", dp_state, 4'b0010);
      check("t1_frame", fd_n - snap, 1);
      check("t1_no_err", ae_n + se_n, 0);

      // T3: two anodes at once for one cycle
      snap = ae_n;
      drive(4'b0101, 7'h7F, 1'b0); tick(1);
      drive(4'b0000, 7'h00, 1'b0); tick(10);
      check("t3_anode_err", ae_n - snap, 1);
      check("t3_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 16'h1234);

      // T4: illegal pattern, then a blank digit carrying only DP
      snap = se_n;
      drive(4'b0010, 7'h49, 1'b0); tick(8);
      drive(4'b0000, 7'h00, 1'b0); tick(10);
      check("t4_seg_err", se_n - snap, 1);
      check("t4_sec2", sec_dig2, 4'h2);
      check("t4_dp", dp_state, 4'b0010);
      drive(4'b0100, 7'h00, 1'b1); tick(8);
      drive(4'b0000, 7'h00, 1'b0); tick(5);
      check("blank_dp", dp_state, 4'b0110);
      check("blank_min1", min_dig1, 4'h3);
      check("blank_no_err", se_n - snap, 1);
      check("stall_low", scan_stall, 1'b0);

      // T5: timeout then recovery
      tick(65540);
      check("t5_stall", scan_stall, 1'b1);
      drive(4'b0001, 7'h6F, 1'b0);
      tick(6);
      check("t5_stall_hold", scan_stall, 1'b1);
      tick(1);
      check("t5_stall_clr", scan_stall, 1'b0);
      check("t5_sec1", sec_dig1, 4'h9);

      // T6: reset in the middle of a dwell
      drive(4'b0010, 7'h7D, 1'b0);
      tick(2);
      reset = 1'b1;
      #1;
      check("t6_digits", {sec_dig1, sec_dig2, min_dig1, min_dig2}, 16'h0000);
      check("t6_flags", {dp_state, digit_valid, frame_done, anode_err, seg_err, scan_stall}, 12'h000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(6);
      check("t6_early", sec_dig2, 4'h0);
      tick(1);
      check("t6_sec2", sec_dig2, 4'h6);
      check("t6_valid", digit_valid, 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
